dvi_tx_packer: RTL and testbench
================================

Name: dvi_tx_packer

Overview:
- Parametrised successor to the fixed 8-bpc DVI output stage.
- Takes timing and RGB from the GPU video timing generator and conditions it for the external DVI transmitter chip.
- Handles colour-depth expansion, phase packing for 12-bit DDR or 24-bit SDR transmitters, equal-latency alignment of sync/DE/data, a timed transmitter reset release, and a frame-synchronous colour-bar test pattern.
- Output phase words feed the I/O-primitive wrapper; the IIC init block is unchanged.

Parameters:
- BPC, 8: input bits per channel; legal range 4..8.
- DDR_MODE, 1: 1 = two 12-bit phase words per pixel; 0 = 24-bit SDR, with {d_fall, d_rise} = {R8, G8, B8}.
- PIPE_STAGES, 2: input-to-output latency in pixel_clk cycles; legal range 1..4.
- RESET_HOLD, 1024: cycles dvi_reset_b is held low after reset release; minimum 1.
- BAR_WIDTH, 80: pixels per colour bar in test pattern; minimum 1.

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- gpuclk_rst_b  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync from timing generator
- vsync  in  1  vertical sync, active high
- blank_b  in  1  active video, high = pixel valid
- pixel_r  in  BPC  red
- pixel_g  in  BPC  green
- pixel_b  in  BPC  blue
- pattern_en  in  1  request colour-bar pattern instead of pixel input
- dvi_reset_b  out  1  transmitter reset, active low
- tx_ready  out  1  high once reset hold complete
- dvi_hs  out  1  delayed hsync
- dvi_vs  out  1  delayed vsync
- dvi_de  out  1  delayed data enable
- dvi_d_rise  out  12  rising-edge phase word
- dvi_d_fall  out  12  falling-edge phase word

Behaviour:
- Reset is asserted asynchronously. While asserted, all pipeline registers clear: dvi_hs = dvi_vs = dvi_de = 0, dvi_d_rise = dvi_d_fall = 0x000, dvi_reset_b = 0, tx_ready = 0, pattern mode = off, bar counters = 0.
- Reset hold:
  - A counter of width clog2(RESET_HOLD+1) increments each cycle after release.
  - When it reaches RESET_HOLD, dvi_reset_b and tx_ready go to 1 on that edge and stay there, with the counter saturating.
  - Reasserting reset mid-operation restarts the hold from zero.
- Before tx_ready, dvi_de and data are forced to 0. Sync signals still propagate through the pipeline.
- Depth expansion:
  - Each channel is expanded to 8 bits as c8[7:8-BPC] = c and c8[7-BPC:0] = c[BPC-1 -: 8-BPC], i.e. MSB replication.
  - BPC = 8 passes the value through unchanged.
- Phase map (both modes):
  - dvi_d_rise = {G8[3:0], B8[7:0]}
  - dvi_d_fall = {R8[7:0], G8[7:4]}
- Latency:
  - hsync, vsync, blank_b and pixel data all pass through exactly PIPE_STAGES registers, so alignment is exact.
  - Stage 1 registers the selected source (pixel or pattern). Expansion and packing happen combinationally before the final stage.
- Blanking: when the delayed DE is 0, both data words are 0x000.
- Pattern mode:
  - pattern_en is sampled on the vsync rising edge (0→1, detected against the registered previous vsync) and held until the next vsync rising edge. Switching therefore never occurs mid-frame.
  - A pattern_en change between vsync edges has no effect.
- Bar generator:
  - A sub-counter of width clog2(BAR_WIDTH) and a 3-bit bar index advance on each blank_b = 1 cycle.
  - When the sub-counter reaches BAR_WIDTH-1 it wraps to 0 and the bar index increments, saturating at 7.
  - Both counters clear on any blank_b = 0 cycle.
  - The colour for the current pixel uses counter values before the increment.
  - Bar order (R,G,B): 0 white FF,FF,FF; 1 yellow FF,FF,00; 2 cyan 00,FF,FF; 3 green 00,FF,00; 4 magenta FF,00,FF; 5 red FF,00,00; 6 blue 00,00,FF; 7 black 00,00,00.
  - Pattern colours are 8-bit and bypass expansion.
- Simultaneous vsync rise and blank_b = 1: the mode latch updates and the counters still follow blank_b.

Decomposition:
- Package dvi_pkg: 24-bit bar colour constants (8-entry), bar count constant, and phase-map bit-position constants shared with the I/O wrapper.
- One sub-module, dvi_bar_gen: the pattern counters and colour lookup.

Test Plan:
- BPC=8, DDR_MODE=1, PIPE_STAGES=2, blank_b=1, R=0xA5 G=0x3C B=0x0F -> two cycles later dvi_d_rise=0xC0F, dvi_d_fall=0xA53, dvi_de=1.
- BPC=4, R=0xA G=0x5 B=0xF -> R8=0xAA, G8=0x55, B8=0xFF; dvi_d_rise=0x5FF, dvi_d_fall=0xAA5.
- RESET_HOLD=16: release reset at cycle 0 -> dvi_reset_b/tx_ready rise at cycle 16; data and de stay 0 before that even with blank_b=1. Pulse reset low at cycle 20 -> outputs clear immediately, ready returns 16 cycles after the new release.
- BAR_WIDTH=4: pattern_en=1, then a vsync rising edge, then a 40-pixel line -> pixels 0-3 give rise 0xFFF / fall 0xFFF; pixels 4-7 give rise 0xF00 / fall 0xFFF; pixels 28-39 are all 0x000. Counters clear when blank_b drops.
- Toggle pattern_en mid-frame -> output source unchanged until the next vsync rising edge.
- blank_b=0 with nonzero pixel input -> dvi_d_rise = dvi_d_fall = 0x000 while hs/vs still track the input delayed by PIPE_STAGES.

Source files
------------

// File: rtl/dvi_pkg.sv
// Shared constants for the DVI output stage: colour-bar table, stage record
// and phase-word bit positions also used by the I/O-primitive wrapper.
package dvi_pkg;

  localparam int unsigned BAR_COUNT = 8;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  // Entry N is bar N as {R8, G8, B8}
  localparam logic [BAR_COUNT-1:0][23:0] BAR_RGB = {
    24'h000000,
    24'h0000FF,
    24'hFF0000,
    24'hFF00FF,
    24'h00FF00,
    24'h00FFFF,
    24'hFFFF00,
    24'hFFFFFF
  };

  // Phase map: rise = {G8[3:0], B8[7:0]}, fall = {R8[7:0], G8[7:4]}
  localparam int unsigned RISE_B_LSB = 0;
  localparam int unsigned RISE_G_LSB = 8;
  localparam int unsigned FALL_G_LSB = 0;
  localparam int unsigned FALL_R_LSB = 4;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } stage_t;

endpackage

// File: rtl/dvi_bar_gen.sv
// Colour-bar generator: per-line pixel counters and bar colour lookup.
// Colour reflects the counters before this cycle's increment.
module dvi_bar_gen
  import dvi_pkg::*;
#(
  parameter int unsigned BAR_WIDTH = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  output logic [23:0] rgb
);

  localparam int unsigned SUB_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  logic [SUB_W-1:0] sub_cnt;
  bar_e             bar_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      bar_idx <= BAR_WHITE;
    end else if (!active) begin
      sub_cnt <= '0;
      bar_idx <= BAR_WHITE;
    end else if (sub_cnt == SUB_W'(BAR_WIDTH - 1)) begin
      sub_cnt <= '0;
      if (bar_idx != BAR_BLACK)
        bar_idx <= bar_e'(bar_idx + 3'd1);
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

  assign rgb = BAR_RGB[bar_idx];

endmodule

// File: rtl/dvi_tx_packer.sv
// DVI transmitter output stage: depth expansion, pattern select, equal-latency
// pipeline, phase packing and timed transmitter reset release.
module dvi_tx_packer
  import dvi_pkg::*;
#(
  parameter int unsigned BPC         = 8,
  parameter int unsigned DDR_MODE    = 1,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned RESET_HOLD  = 1024,
  parameter int unsigned BAR_WIDTH   = 80
) (
  input  logic           pixel_clk,
  input  logic           gpuclk_rst_b,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           blank_b,
  input  logic [BPC-1:0] pixel_r,
  input  logic [BPC-1:0] pixel_g,
  input  logic [BPC-1:0] pixel_b,
  input  logic           pattern_en,
  output logic           dvi_reset_b,
  output logic           tx_ready,
  output logic           dvi_hs,
  output logic           dvi_vs,
  output logic           dvi_de,
  output logic [11:0]    dvi_d_rise,
  output logic [11:0]    dvi_d_fall
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      hold_cnt    <= '0;
      tx_ready    <= 1'b0;
      dvi_reset_b <= 1'b0;
    end else if (!tx_ready) begin
      hold_cnt <= hold_cnt + 1'b1;
      if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
        tx_ready    <= 1'b1;
        dvi_reset_b <= 1'b1;
      end
    end
  end

  // Pattern request only takes effect on a vsync rising edge
  logic vs_prev;
  logic pat_mode;

  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      vs_prev  <= 1'b0;
      pat_mode <= 1'b0;
    end else begin
      vs_prev <= vsync;
      if (vsync && !vs_prev)
        pat_mode <= pattern_en;
    end
  end

  logic [7:0] r8, g8, b8;

  generate
    if (BPC == 8) begin : g_pass
      assign r8 = pixel_r;
      assign g8 = pixel_g;
      assign b8 = pixel_b;
    end else begin : g_expand
      assign r8 = {pixel_r, pixel_r[BPC-1 -: 8-BPC]};
      assign g8 = {pixel_g, pixel_g[BPC-1 -: 8-BPC]};
      assign b8 = {pixel_b, pixel_b[BPC-1 -: 8-BPC]};
    end
  endgenerate

  logic [23:0] bar_rgb;

  dvi_bar_gen #(
    .BAR_WIDTH(BAR_WIDTH)
  ) u_bar_gen (
    .clk   (pixel_clk),
    .rst_n (gpuclk_rst_b),
    .active(blank_b),
    .rgb   (bar_rgb)
  );

  stage_t src;
  stage_t pre_final;

  always_comb begin
    src.hs  = hsync;
    src.vs  = vsync;
    src.de  = blank_b;
    src.rgb = pat_mode ? bar_rgb : {r8, g8, b8};
  end

  // Output registers count as the last stage, so only PIPE_STAGES-1 live here
  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign pre_final = src;
    end else begin : g_pipe
      stage_t pipe [PIPE_STAGES-1];

      always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
        if (!gpuclk_rst_b) begin
          for (int unsigned i = 0; i < PIPE_STAGES - 1; i++)
            pipe[i] <= '0;
        end else begin
          pipe[0] <= src;
          for (int unsigned i = 1; i < PIPE_STAGES - 1; i++)
            pipe[i] <= pipe[i-1];
        end
      end

      assign pre_final = pipe[PIPE_STAGES-2];
    end
  endgenerate

  logic [11:0] rise_w;
  logic [11:0] fall_w;

  generate
    if (DDR_MODE != 0) begin : g_ddr
      always_comb begin
        rise_w = '0;
        fall_w = '0;
        rise_w[RISE_B_LSB +: 8] = pre_final.rgb[7:0];
        rise_w[RISE_G_LSB +: 4] = pre_final.rgb[11:8];
        fall_w[FALL_G_LSB +: 4] = pre_final.rgb[15:12];
        fall_w[FALL_R_LSB +: 8] = pre_final.rgb[23:16];
      end
    end else begin : g_sdr
      assign {fall_w, rise_w} = pre_final.rgb;
    end
  endgenerate

  logic de_ok;
  assign de_ok = pre_final.de & tx_ready;

  always_ff @(posedge pixel_clk or negedge gpuclk_rst_b) begin
    if (!gpuclk_rst_b) begin
      dvi_hs     <= 1'b0;
      dvi_vs     <= 1'b0;
      dvi_de     <= 1'b0;
      dvi_d_rise <= '0;
      dvi_d_fall <= '0;
    end else begin
      dvi_hs     <= pre_final.hs;
      dvi_vs     <= pre_final.vs;
      dvi_de     <= de_ok;
      dvi_d_rise <= de_ok ? rise_w : '0;
      dvi_d_fall <= de_ok ? fall_w : '0;
    end
  end

endmodule

// File: tb/tb_dvi_tx_packer.sv
// Directed bench for dvi_tx_packer: an 8-bpc instance carries most scenarios,
// a 4-bpc instance covers MSB-replication expansion.
module tb_dvi_tx_packer;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       blank_b = 1'b0;
  logic       pattern_en = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [3:0] r4 = '0, g4 = '0, b4 = '0;

  logic        reset_b, ready, hs, vs, de;
  logic [11:0] rise, fall;
  logic        a_reset_b, a_ready, a_hs, a_vs, a_de;
  logic [11:0] a_rise, a_fall;

  int errors = 0;
  int checks = 0;

  // {rise, fall} per bar, worked out by hand from the R,G,B bar colours
  localparam logic [23:0] BAR_RF [8] = '{
    24'hFFF_FFF, 24'hF00_FFF, 24'hFFF_00F, 24'hF00_00F,
    24'h0FF_FF0, 24'h000_FF0, 24'h0FF_000, 24'h000_000
  };
  localparam logic [7:0]  V8_R [3] = '{8'hA5, 8'h12, 8'hFF};
  localparam logic [7:0]  V8_G [3] = '{8'h3C, 8'h34, 8'h00};
  localparam logic [7:0]  V8_B [3] = '{8'h0F, 8'h56, 8'h80};
  localparam logic [23:0] V8_RF [3] = '{24'hC0F_A53, 24'h456_123, 24'h080_FF0};
  localparam logic [3:0]  V4_R [3] = '{4'hA, 4'h3, 4'h1};
  localparam logic [3:0]  V4_G [3] = '{4'h5, 4'hC, 4'h8};
  localparam logic [3:0]  V4_B [3] = '{4'hF, 4'h0, 4'h7};
  localparam logic [23:0] V4_RF [3] = '{24'h5FF_AA5, 24'hC00_33C, 24'h877_118};

  always #5 clk = ~clk;

  dvi_tx_packer #(
    .BPC(8), .DDR_MODE(1), .PIPE_STAGES(2), .RESET_HOLD(16), .BAR_WIDTH(4)
  ) u_dut (
    .pixel_clk(clk), .gpuclk_rst_b(rst_b), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .pixel_r(r), .pixel_g(g), .pixel_b(b),
    .pattern_en(pattern_en), .dvi_reset_b(reset_b), .tx_ready(ready),
    .dvi_hs(hs), .dvi_vs(vs), .dvi_de(de), .dvi_d_rise(rise), .dvi_d_fall(fall)
  );

  dvi_tx_packer #(
    .BPC(4), .DDR_MODE(1), .PIPE_STAGES(2), .RESET_HOLD(16), .BAR_WIDTH(80)
  ) u_dut4 (
    .pixel_clk(clk), .gpuclk_rst_b(rst_b), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .pixel_r(r4), .pixel_g(g4), .pixel_b(b4),
    .pattern_en(pattern_en), .dvi_reset_b(a_reset_b), .tx_ready(a_ready),
    .dvi_hs(a_hs), .dvi_vs(a_vs), .dvi_de(a_de), .dvi_d_rise(a_rise), .dvi_d_fall(a_fall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({reset_b, ready, hs, vs, de} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {reset_b, ready, hs, vs, de});
    end
    checks++;
    if ({rise, fall} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 000000", {rise, fall});
    end
    tick();
    blank_b = 1'b1; hsync = 1'b1;
    r = V8_R[0]; g = V8_G[0]; b = V8_B[0];
    r4 = V4_R[0]; g4 = V4_G[0]; b4 = V4_B[0];
    rst_b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 2) begin
        checks++;
        if (hs !== 1'b1) begin
          errors++;
          $display("FAIL hs_before_ready: got %b expected 1", hs);
        end
      end
      if (k == 15) begin
        checks++;
        if ({reset_b, ready, a_ready, de} !== 4'b0) begin
          errors++;
          $display("FAIL hold_not_done: got %b expected 0000", {reset_b, ready, a_ready, de});
        end
        checks++;
        if ({rise, fall} !== 24'h0) begin
          errors++;
          $display("FAIL data_before_ready: got %h expected 000000", {rise, fall});
        end
      end
      if (k == 16) begin
        checks++;
        if ({reset_b, ready, a_ready} !== 3'b111) begin
          errors++;
          $display("FAIL hold_done: got %b expected 111", {reset_b, ready, a_ready});
        end
      end
    end
  endtask

  task automatic test_pixel_paths;
    hsync = 1'b0;
    for (int v = 0; v < 3; v++) begin
      r = V8_R[v]; g = V8_G[v]; b = V8_B[v];
      r4 = V4_R[v]; g4 = V4_G[v]; b4 = V4_B[v];
      blank_b = 1'b1;
      tick();
      tick();
      checks++;
      if ({de, rise, fall} !== {1'b1, V8_RF[v]}) begin
        errors++;
        $display("FAIL pixel8_v%0d: got %h expected %h", v, {de, rise, fall}, {1'b1, V8_RF[v]});
      end
      checks++;
      if ({a_rise, a_fall} !== V4_RF[v]) begin
        errors++;
        $display("FAIL pixel4_v%0d: got %h expected %h", v, {a_rise, a_fall}, V4_RF[v]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int s = 0; s <= 3; s++) begin
      if (s < 3) begin
        r = V8_R[s]; g = V8_G[s]; b = V8_B[s];
        blank_b = 1'b1;
      end else begin
        blank_b = 1'b0;
      end
      tick();
      if (s == 0) begin
        checks++;
        if ({rise, fall} !== V8_RF[2]) begin
          errors++;
          $display("FAIL latency_hold: got %h expected %h", {rise, fall}, V8_RF[2]);
        end
      end else begin
        checks++;
        if ({rise, fall} !== V8_RF[s-1]) begin
          errors++;
          $display("FAIL b2b_%0d: got %h expected %h", s - 1, {rise, fall}, V8_RF[s-1]);
        end
      end
    end
    tick();
    checks++;
    if ({de, rise, fall} !== 25'h0) begin
      errors++;
      $display("FAIL b2b_blank: got %h expected 0000000", {de, rise, fall});
    end
  endtask

  task automatic test_blanking;
    blank_b = 1'b0;
    r = 8'hFF; g = 8'hEE; b = 8'hDD;
    r4 = 4'hF; g4 = 4'hE; b4 = 4'hD;
    hsync = 1'b1; vsync = 1'b1;
    tick();
    hsync = 1'b0; vsync = 1'b0;
    tick();
    checks++;
    if ({hs, vs, de} !== 3'b110) begin
      errors++;
      $display("FAIL blank_sync_hi: got %b expected 110", {hs, vs, de});
    end
    checks++;
    if ({rise, fall, a_rise, a_fall} !== 48'h0) begin
      errors++;
      $display("FAIL blank_data: got %h expected 0", {rise, fall, a_rise, a_fall});
    end
    tick();
    checks++;
    if ({hs, vs} !== 2'b00) begin
      errors++;
      $display("FAIL blank_sync_lo: got %b expected 00", {hs, vs});
    end
  endtask

  task automatic test_pattern;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;
    int          px;
    r = V8_R[0]; g = V8_G[0]; b = V8_B[0];
    pattern_en = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    // 40-pixel line, 3 blanking cycles, then a 6-pixel line from cleared counters
    for (int s = 0; s <= 49; s++) begin
      if (s < 49) begin
        blank_b = (s < 40) || (s >= 43);
        px = (s < 40) ? s : s - 43;
        if (!blank_b) exp_v = 24'h0;
        else exp_v = BAR_RF[(px / 4 > 7) ? 7 : px / 4];
        exp_q.push_back(exp_v);
      end else begin
        blank_b = 1'b0;
      end
      tick();
      if (s >= 1) begin
        exp_v = exp_q.pop_front();
        checks++;
        if ({rise, fall} !== exp_v) begin
          errors++;
          $display("FAIL bar_step%0d: got %h expected %h", s - 1, {rise, fall}, exp_v);
        end
      end
    end
  endtask

  task automatic test_mode_hold;
    r = V8_R[1]; g = V8_G[1]; b = V8_B[1];
    pattern_en = 1'b0;
    blank_b = 1'b1;
    tick();
    tick();
    checks++;
    if ({rise, fall} !== BAR_RF[0]) begin
      errors++;
      $display("FAIL mode_hold_on: got %h expected %h", {rise, fall}, BAR_RF[0]);
    end
    blank_b = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    blank_b = 1'b1;
    tick();
    tick();
    checks++;
    if ({rise, fall} !== V8_RF[1]) begin
      errors++;
      $display("FAIL mode_off: got %h expected %h", {rise, fall}, V8_RF[1]);
    end
    pattern_en = 1'b1;
    tick();
    tick();
    checks++;
    if ({rise, fall} !== V8_RF[1]) begin
      errors++;
      $display("FAIL mode_hold_off: got %h expected %h", {rise, fall}, V8_RF[1]);
    end
  endtask

  task automatic test_reset_pulse;
    checks++;
    if (de !== 1'b1) begin
      errors++;
      $display("FAIL pulse_pre_de: got %b expected 1", de);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if ({reset_b, ready, de, rise, fall} !== 27'h0) begin
      errors++;
      $display("FAIL pulse_clear: got %h expected 0", {reset_b, ready, de, rise, fall});
    end
    tick();
    rst_b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        checks++;
        if ({reset_b, ready, de} !== 3'b000) begin
          errors++;
          $display("FAIL pulse_hold: got %b expected 000", {reset_b, ready, de});
        end
      end
      if (k == 16) begin
        checks++;
        if ({reset_b, ready} !== 2'b11) begin
          errors++;
          $display("FAIL pulse_ready: got %b expected 11", {reset_b, ready});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_paths();
    test_back_to_back();
    test_blanking();
    test_pattern();
    test_mode_hold();
    test_reset_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
